// File: rtl/m_imem_loader.sv
// UART (8N1) program loader feeding the instruction memory write port.
// Ports: w_clk/w_rst_n, w_rxd in; r_we/r_addr/r_wdata imem write; r_prst/r_done/r_err status.
module m_imem_loader #(
  parameter int DIV    = 434,
  parameter int ADDR_W = 12
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_prst,
  output logic              r_done,
  output logic              r_err
);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_BITS, R_STOP, R_WAIT
  } rx_e;

  typedef enum logic [1:0] {
    S_HDR0, S_HDR1, S_DATA, S_DONE
  } ld_e;

  // edge detect costs one cycle, so the half-bit wait is one shorter
  localparam logic [15:0] HALF = 16'(DIV / 2 - 2);
  localparam logic [15:0] FULL = 16'(DIV - 1);

  logic        s1, s2, s3;
  rx_e         rx_st, rx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bitn, bit_nxt;
  logic [7:0]  sh, sh_nxt;
  logic        bvld, bvld_nxt;
  logic        ferr, ferr_nxt;

  ld_e         st, st_nxt;
  logic [15:0] n;
  logic [15:0] idx;
  logic [15:0] idx_inc;
  logic [1:0]  bcnt;
  logic [23:0] asm_r;
  logic [31:0] word;
  logic        last;

  assign idx_inc = idx + 16'd1;
  assign word    = {asm_r, sh};

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s3    <= 1'b1;
      rx_st <= R_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
      bvld  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      s1    <= w_rxd;
      s2    <= s1;
      s3    <= s2;
      rx_st <= rx_nxt;
      cnt   <= cnt_nxt;
      bitn  <= bit_nxt;
      sh    <= sh_nxt;
      bvld  <= bvld_nxt;
      ferr  <= ferr_nxt;
    end
  end

  always_comb begin
    rx_nxt   = rx_st;
    cnt_nxt  = cnt;
    bit_nxt  = bitn;
    sh_nxt   = sh;
    bvld_nxt = 1'b0;
    ferr_nxt = 1'b0;
    unique case (rx_st)
      R_IDLE: begin
        if (s3 && !s2) begin
          rx_nxt  = R_START;
          cnt_nxt = HALF;
        end
      end
      R_START: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (s2) begin
          rx_nxt = R_IDLE;
        end else begin
          rx_nxt  = R_BITS;
          cnt_nxt = FULL;
          bit_nxt = 3'd0;
        end
      end
      R_BITS: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else begin
          sh_nxt  = {s2, sh[7:1]};
          cnt_nxt = FULL;
          if (bitn == 3'd7) rx_nxt = R_STOP;
          else bit_nxt = bitn + 3'd1;
        end
      end
      R_STOP: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (s2) begin
          bvld_nxt = 1'b1;
          rx_nxt   = R_IDLE;
        end else begin
          ferr_nxt = 1'b1;
          rx_nxt   = R_WAIT;
        end
      end
      R_WAIT: begin
        if (s2) rx_nxt = R_IDLE;
      end
      default: rx_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) st <= S_HDR0;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_HDR0: if (bvld) st_nxt = S_HDR1;
      S_HDR1: begin
        if (bvld) begin
          if ({n[15:8], sh} == 16'd0) st_nxt = S_DONE;
          else                        st_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bvld && bcnt == 2'd3 && idx_inc == n)
          st_nxt = S_DONE;
      end
      S_DONE:  st_nxt = S_DONE;
      default: st_nxt = S_HDR0;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_prst  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      n       <= '0;
      idx     <= '0;
      bcnt    <= '0;
      asm_r   <= '0;
      last    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      last <= 1'b0;
      if (ferr && st != S_DONE) r_err <= 1'b1;
      // release one cycle after the final word slot
      if (last) begin
        r_done <= 1'b1;
        r_prst <= 1'b0;
      end
      unique case (st)
        S_HDR0: if (bvld) n[15:8] <= sh;
        S_HDR1: begin
          if (bvld) begin
            n[7:0] <= sh;
            idx    <= '0;
            bcnt   <= '0;
            if ({n[15:8], sh} == 16'd0) begin
              r_done <= 1'b1;
              r_prst <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (bvld) begin
            asm_r <= word[23:0];
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              idx  <= idx_inc;
              last <= (idx_inc == n);
              if ((32'(idx) >> ADDR_W) == 32'd0) begin
                r_we    <= 1'b1;
                r_addr  <= idx[ADDR_W-1:0];
                r_wdata <= word;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
